// File: rtl/semaforo_temporizado.sv
// Timed phase sequencer for a three-road intersection: green hold, yellow, optional all-red.
// Optional all-red clearance phase is enabled by defining SEMAFORO_ALLRED_EN.
module semaforo_temporizado #(
  parameter int MIN_GREEN = 5,
  parameter int YELLOW_T  = 2,
  parameter int ALL_RED_T = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] req_green,
  output logic [2:0] lamp_r,
  output logic [2:0] lamp_y,
  output logic [2:0] lamp_g,
  output logic [1:0] road,
  output logic [1:0] phase
);

  localparam int CNT_MAX_GY = (MIN_GREEN > YELLOW_T) ? MIN_GREEN : YELLOW_T;
  localparam int CNT_MAX    = (CNT_MAX_GY > ALL_RED_T) ? CNT_MAX_GY : ALL_RED_T;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MG_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] YE_LAST = CW'(YELLOW_T - 1);
`ifdef SEMAFORO_ALLRED_EN
  localparam logic [CW-1:0] AR_LAST = CW'(ALL_RED_T - 1);
`endif

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic [1:0]    nxt_q, nxt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       req_valid;
  logic [1:0] req_road;
  logic [2:0] cur_onehot;

  // Only a strictly one-hot request names a road; anything else means "no change".
  always_comb begin
    req_valid = 1'b1;
    req_road  = 2'd0;
    case (req_green)
      3'b001:  req_road = 2'd0;
      3'b010:  req_road = 2'd1;
      3'b100:  req_road = 2'd2;
      default: req_valid = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        ST_GREEN: begin
          if (cnt_q >= MG_LAST && req_valid && req_road != cur_q) begin
            nxt_d   = req_road;
            state_d = ST_YELLOW;
            cnt_d   = '0;
          end else if (cnt_q < MG_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_YELLOW: begin
          if (cnt_q == YE_LAST) begin
`ifdef SEMAFORO_ALLRED_EN
            state_d = ST_ALL_RED;
`else
            state_d = ST_GREEN;
            cur_d   = nxt_q;
`endif
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SEMAFORO_ALLRED_EN
        ST_ALL_RED: begin
          if (cnt_q == AR_LAST) begin
            state_d = ST_GREEN;
            cur_d   = nxt_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = ST_GREEN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and beats tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_GREEN;
      cur_q   <= 2'd0;
      nxt_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lamps decode registered state only, so exactly one lamp per road is lit every cycle.
  assign cur_onehot = 3'b001 << cur_q;

  always_comb begin
    lamp_g = 3'b000;
    lamp_y = 3'b000;
    lamp_r = 3'b111;
    case (state_q)
      ST_GREEN: begin
        lamp_g = cur_onehot;
        lamp_r = ~cur_onehot;
      end
      ST_YELLOW: begin
        lamp_y = cur_onehot;
        lamp_r = ~cur_onehot;
      end
      default: ;
    endcase
  end

  assign road  = cur_q;
  assign phase = state_q;

endmodule
